// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
// Module   : main_memory
// Brief    : Line-granular backing store behind the I$/D$ arbiter; serves one
//            cache line per request after a fixed latency.
// Revision : 1.1
// ============================================================================
module main_memory #(
    parameter int    ADDRESS_WIDTH    = 32,
    parameter int    CACHE_LINE_WIDTH = 128,
    parameter int    MEM_LATENCY      = 5,
    parameter int    MEM_LINES        = 4096,
    parameter string INIT_FILE        = ""
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mem_req,
    input  logic                        mem_write,
    input  logic [ADDRESS_WIDTH-1:0]    mem_addr,
    input  logic [CACHE_LINE_WIDTH-1:0] mem_data,
    output logic                        mem_ready,
    output logic [CACHE_LINE_WIDTH-1:0] mem_rdata,
    output logic                        mem_busy
);

    localparam int         C_OFF    = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int         C_IDX_W  = $clog2(MEM_LINES);
    localparam logic [7:0] C_LAT_M1 = 8'(MEM_LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]                  r_state;
    logic [7:0]                  r_count;
    logic                        r_write;
    logic [C_IDX_W-1:0]          r_index;
    logic [CACHE_LINE_WIDTH-1:0] r_data;
    logic [CACHE_LINE_WIDTH-1:0] r_mem [0:MEM_LINES-1];

    logic [C_IDX_W-1:0]          w_index;
    logic                        w_unused_addr;

    // Offset bits and bits above the line index are dropped, so accesses wrap.
    assign w_index       = mem_addr[C_OFF +: C_IDX_W];
    assign w_unused_addr = ^mem_addr;

    // Storage has no reset; a reset landing in RESP suppresses the commit.
    always_ff @(posedge clk) begin
        if (!reset && r_state == S_RESP && r_write) begin
            r_mem[r_index] <= r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 8'd0;
            r_write   <= 1'b0;
            r_index   <= '0;
            r_data    <= '0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_req) begin
                        r_write  <= mem_write;
                        r_index  <= w_index;
                        r_data   <= mem_data;
                        r_count  <= C_LAT_M1;
                        mem_busy <= 1'b1;
                        // A single-cycle latency skips BUSY entirely.
                        if (MEM_LATENCY == 1) begin
                            r_state   <= S_RESP;
                            mem_ready <= 1'b1;
                            if (!mem_write) begin
                                mem_rdata <= r_mem[w_index];
                            end
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_count <= r_count - 8'd1;
                    if (r_count == 8'd1) begin
                        r_state   <= S_RESP;
                        mem_ready <= 1'b1;
                        if (!r_write) begin
                            mem_rdata <= r_mem[r_index];
                        end
                    end
                end
                S_RESP: begin
                    if (mem_req) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state  <= S_IDLE;
                        mem_busy <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Wait out a request the arbiter is still holding.
                    if (!mem_req) begin
                        r_state  <= S_IDLE;
                        mem_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    mem_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
